// File: rtl/seg7_word_decoder.sv
// Recovers 2-bit character codes from active-low 7-segment patterns on HEX0..HEX2,
// qualifies each digit with a stability filter and presents a 6-bit word on a valid/ack
// handshake. Define SEG7_ROTATION_DETECT_EN to add the word-rotation indicator on ROT.
module seg7_word_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [0:6] SEG,
  input  logic [1:0] DIG_SEL,
  input  logic       SEG_VALID,
  input  logic       WORD_ACK,
  input  logic       CLR_FLAGS,
  output logic [5:0] WORD,
  output logic       WORD_VALID,
  output logic [2:0] CHAR_SEEN,
  output logic       BAD_PAT,
  output logic       OVERRUN,
  output logic       ROT
);

  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

  state_t          state, state_n;
  logic [0:6]      cand_pat, cand_pat_n;
  logic [1:0]      cand_dig, cand_dig_n;
  logic [3:0]      cnt, cnt_n;
  logic            commit;
  logic            sample, match;
  logic [1:0]      code;
  logic            pat_ok;
  logic [2:0][1:0] char_q;
  logic [2:0]      seen_n;
  logic            load;
  logic [5:0]      word_n;

  assign sample = SEG_VALID && (DIG_SEL != 2'd3);
  assign match  = (SEG == cand_pat) && (DIG_SEL == cand_dig);
  assign load   = (CHAR_SEEN == 3'b111);
  assign word_n = {char_q[2], char_q[1], char_q[0]};

  always_comb begin
    code   = 2'd0;
    pat_ok = 1'b1;
    case (SEG)
      7'b0111101: code = 2'd0;
      7'b1001111: code = 2'd1;
      7'b0110000: code = 2'd2;
      7'b0000000: code = 2'd3;
      default:    pat_ok = 1'b0;
    endcase
  end

  // Any non-matching sample restarts tracking; with STABLE_CYCLES=1 it commits at once.
  always_comb begin
    state_n    = state;
    cand_pat_n = cand_pat;
    cand_dig_n = cand_dig;
    cnt_n      = cnt;
    commit     = 1'b0;
    if (sample) begin
      if (state != IDLE && match) begin
        if (state == TRACK) begin
          cnt_n = cnt + 4'd1;
          if ((cnt + 4'd1) == STABLE) begin
            commit  = 1'b1;
            state_n = LOCKED;
          end
        end
      end else begin
        cand_pat_n = SEG;
        cand_dig_n = DIG_SEL;
        cnt_n      = 4'd1;
        if (STABLE == 4'd1) begin
          commit  = 1'b1;
          state_n = LOCKED;
        end else begin
          state_n = TRACK;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= IDLE;
      cand_pat <= '0;
      cand_dig <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      cand_pat <= cand_pat_n;
      cand_dig <= cand_dig_n;
      cnt      <= cnt_n;
    end
  end

  // A commit on the load edge belongs to the next word, so it survives the clear.
  always_comb begin
    seen_n = load ? 3'b000 : CHAR_SEEN;
    if (commit && pat_ok) seen_n[DIG_SEL] = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      char_q     <= '0;
      CHAR_SEEN  <= '0;
      WORD       <= '0;
      WORD_VALID <= 1'b0;
      BAD_PAT    <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      CHAR_SEEN <= seen_n;
      if (commit && pat_ok) char_q[DIG_SEL] <= code;
      if (load) begin
        WORD       <= word_n;
        WORD_VALID <= 1'b1;
      end else if (WORD_ACK) begin
        WORD_VALID <= 1'b0;
      end
      if (commit && !pat_ok) BAD_PAT <= 1'b1;
      else if (CLR_FLAGS)    BAD_PAT <= 1'b0;
      if (load && WORD_VALID && !WORD_ACK) OVERRUN <= 1'b1;
      else if (CLR_FLAGS)                  OVERRUN <= 1'b0;
    end
  end

`ifdef SEG7_ROTATION_DETECT_EN
  logic [5:0] prev_word;
  logic       have_prev;

  // The first word after reset has no predecessor, so it never reports a rotation.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      prev_word <= '0;
      have_prev <= 1'b0;
      ROT       <= 1'b0;
    end else if (load) begin
      ROT       <= have_prev && (word_n == {prev_word[3:0], prev_word[5:4]});
      prev_word <= word_n;
      have_prev <= 1'b1;
    end
  end
`else
  assign ROT = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Scoreboard bench for seg7_word_decoder: stimulus pushes expected words, a monitor
// pops and compares them whenever a new word appears on WORD/WORD_VALID.
module tb_seg7_word_decoder;
  logic       clk = 1'b0;
  logic       resetn;
  logic [0:6] seg;
  logic [1:0] dig_sel;
  logic       seg_valid, word_ack, clr_flags;
  logic [5:0] word;
  logic       word_valid;
  logic [2:0] char_seen;
  logic       bad_pat, overrun, rot;

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];
  logic [5:0] m_prev;
  logic       m_have;

  seg7_word_decoder #(.STABLE_CYCLES(4)) dut (
    .Clock(clk), .Resetn(resetn), .SEG(seg), .DIG_SEL(dig_sel), .SEG_VALID(seg_valid),
    .WORD_ACK(word_ack), .CLR_FLAGS(clr_flags), .WORD(word), .WORD_VALID(word_valid),
    .CHAR_SEEN(char_seen), .BAD_PAT(bad_pat), .OVERRUN(overrun), .ROT(rot)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [0:6] pat(input logic [1:0] c);
    logic [0:6] p;
    case (c)
      2'd0: p = 7'b0111101;
      2'd1: p = 7'b1001111;
      2'd2: p = 7'b0110000;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] d, input logic [0:6] p, input int n);
    for (int i = 0; i < n; i++) begin
      seg_valid = 1'b1;
      seg       = p;
      dig_sel   = d;
      tick();
    end
    seg_valid = 1'b0;
  endtask

  task automatic send_word(input logic [5:0] w);
    send(2'd0, pat(w[1:0]), 4);
    send(2'd1, pat(w[3:2]), 4);
    send(2'd2, pat(w[5:4]), 4);
  endtask

  task automatic expect_word(input logic [5:0] w);
    logic r;
    r = 1'b0;
`ifdef SEG7_ROTATION_DETECT_EN
    r = m_have && (w == {m_prev[3:0], m_prev[5:4]});
`endif
    m_prev = w;
    m_have = 1'b1;
    exp_q.push_back({r, w});
  endtask

  task automatic ack_pulse();
    word_ack = 1'b1;
    tick();
    word_ack = 1'b0;
  endtask

  // Monitor: a word is presented when WORD_VALID rises or WORD changes while valid.
  initial begin : monitor
    logic       pv;
    logic [5:0] pw;
    logic [6:0] e;
    pv = 1'b0;
    pw = '0;
    forever begin
      @(negedge clk);
      if (word_valid && (!pv || word != pw)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %b expected none", word);
        end else begin
          e = exp_q.pop_front();
          if ({rot, word} !== e) begin
            errors++;
            $display("FAIL word: got rot=%b word=%b expected rot=%b word=%b",
                     rot, word, e[6], e[5:0]);
          end
        end
      end
      pv = word_valid;
      pw = word;
    end
  end

  initial begin
    m_prev = '0; m_have = 1'b0;
    resetn = 1'b0; seg = '1; dig_sel = '0;
    seg_valid = 1'b0; word_ack = 1'b0; clr_flags = 1'b0;
    #12;
    chk("rst_word", {2'b0, word}, 8'h00);
    chk("rst_flags", {3'b0, word_valid, bad_pat, overrun, rot, 1'b0}, 8'h00);
    chk("rst_seen", {5'b0, char_seen}, 8'h00);
    @(negedge clk); resetn = 1'b1;
    tick();

    // 1: basic word, latency and handshake
    expect_word(6'b001001);
    send_word(6'b001001);
    chk("t1_seen_full", {5'b0, char_seen}, 8'h07);
    chk("t1_valid_lat0", {7'b0, word_valid}, 8'h00);
    tick();
    chk("t1_valid_lat1", {7'b0, word_valid}, 8'h01);
    chk("t1_seen_clr", {5'b0, char_seen}, 8'h00);
    repeat (3) tick();
    chk("t1_hold", {2'b0, word_valid, word[4:0]}, {2'b0, 1'b1, 5'b01001});
    ack_pulse();
    chk("t1_ack", {7'b0, word_valid}, 8'h00);

    // 2: unstable digit does not commit
    send(2'd0, 7'b1001111, 3);
    send(2'd0, 7'b0110000, 1);
    chk("t2_nocommit", {5'b0, char_seen}, 8'h00);
    send(2'd0, 7'b0110000, 3);
    chk("t2_commit", {5'b0, char_seen}, 8'h01);

    // 3: invalid pattern, flag clear, then finish word {01,11,10}
    send(2'd1, 7'b1111111, 4);
    chk("t3_bad", {7'b0, bad_pat}, 8'h01);
    chk("t3_seen", {5'b0, char_seen}, 8'h01);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("t3_clr", {7'b0, bad_pat}, 8'h00);
    expect_word(6'b011110);
    send(2'd1, pat(2'd3), 4);
    send(2'd2, pat(2'd1), 4);
    tick();
    ack_pulse();

    // 4: overrun, then load with ack on the same edge
    expect_word(6'b110110);
    send_word(6'b110110);
    tick();
    expect_word(6'b000111);
    send_word(6'b000111);
    tick();
    chk("t4_overrun", {7'b0, overrun}, 8'h01);
    chk("t4_word", {2'b0, word}, 8'h07);
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    chk("t4_ovr_clr", {7'b0, overrun}, 8'h00);
    expect_word(6'b001001);
    send_word(6'b001001);
    ack_pulse();
    chk("t4_noovr", {6'b0, word_valid, overrun}, 8'h02);

    // 5: rotation detection
    ack_pulse();
    expect_word(6'b100100);
    send_word(6'b100100);
    tick();
`ifdef SEG7_ROTATION_DETECT_EN
    chk("t5_rot1", {7'b0, rot}, 8'h01);
`else
    chk("t5_rot_tied", {7'b0, rot}, 8'h00);
`endif
    ack_pulse();
    expect_word(6'b100100);
    send_word(6'b100100);
    tick();
    chk("t5_rot0", {7'b0, rot}, 8'h00);

    // 6: reset mid-word discards partial word and all state
    send(2'd1, 7'b1111111, 4);
    send(2'd0, pat(2'd2), 4);
    send(2'd1, pat(2'd3), 4);
    chk("t6_seen", {5'b0, char_seen}, 8'h03);
    chk("t6_pre", {6'b0, word_valid, bad_pat}, 8'h03);
    #3 resetn = 1'b0;
    #1;
    chk("t6_rst_word", {2'b0, word}, 8'h00);
    chk("t6_rst_flags", {3'b0, word_valid, bad_pat, overrun, rot, 1'b0}, 8'h00);
    chk("t6_rst_seen", {5'b0, char_seen}, 8'h00);
    m_prev = '0; m_have = 1'b0;
    @(negedge clk); resetn = 1'b1;
    send(2'd2, pat(2'd0), 4);
    repeat (3) tick();
    chk("t6_novalid", {7'b0, word_valid}, 8'h00);
    chk("t6_seen_dig2", {5'b0, char_seen}, 8'h04);

    repeat (2) tick();
    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg7_word_decoder.md
Name: seg7_word_decoder

Overview:
- Reverse direction of the HEX character path: takes the active-low 7-segment patterns driven toward HEX0..HEX2 and recovers the 2-bit character codes.
- Patterns arrive one digit at a time, tagged with a digit index.
- A stability filter qualifies each digit before it is committed.
- Once all three digits are committed, the block assembles a 6-bit word and presents it on a valid/ack handshake.
- Sits on the self-check/loopback path next to the display logic.

Parameters:
- STABLE_CYCLES, 4: consecutive identical SEG_VALID samples (same pattern, same digit) required to commit; legal range 1..15.

Ports:
- Clock, input, 1: single clock; all state changes on its rising edge.
- Resetn, input, 1: asynchronous, active-low reset.
- SEG, input, 7 [0:6]: segment pattern; SEG[0]=a … SEG[6]=g; 0 = segment lit.
- DIG_SEL, input, 2: digit the pattern belongs to (0,1,2); 3 is ignored.
- SEG_VALID, input, 1: SEG/DIG_SEL sampled on this edge.
- WORD_ACK, input, 1: consumer accepts WORD.
- CLR_FLAGS, input, 1: synchronous clear of BAD_PAT and OVERRUN.
- WORD, output, 6: {char2, char1, char0}.
- WORD_VALID, output, 1: WORD holds an unacknowledged word.
- CHAR_SEEN, output, 3: per-digit committed-since-last-word mask.
- BAD_PAT, output, 1: sticky; an unrecognised pattern was qualified.
- OVERRUN, output, 1: sticky; a word was overwritten before ack.
- ROT, output, 1: rotation indicator; see Optional Feature.

Behaviour:
- Pattern table, written SEG[0]..SEG[6]:
  - 0111101 → 00
  - 1001111 → 01
  - 0110000 → 10
  - 0000000 → 11
  - Any other pattern is invalid.
- Reset (Resetn=0, asynchronous):
  - Filter state IDLE, counter 0.
  - CHAR regs 0, CHAR_SEEN 000.
  - WORD 000000, WORD_VALID 0, BAD_PAT 0, OVERRUN 0, ROT 0.
  - Reset mid-word discards the partial word.
- Filter FSM (candidate pattern, candidate digit, 4-bit count). Transitions below apply only on edges with SEG_VALID=1 and DIG_SEL≠3; all other edges leave the FSM unchanged.
  - IDLE: load candidate, count=1 → TRACK. If STABLE_CYCLES=1: commit and → LOCKED.
  - TRACK, sample matches candidate: count+1. If count reaches STABLE_CYCLES: commit → LOCKED.
  - TRACK, sample differs (pattern or digit): reload candidate, count=1, stay TRACK.
  - LOCKED, sample matches: no action, no re-commit.
  - LOCKED, sample differs: reload candidate, count=1 → TRACK (commit immediately if STABLE_CYCLES=1).
- Commit, on the qualifying edge E:
  - Valid pattern: CHAR[dig] ← code, CHAR_SEEN[dig] ← 1.
  - Invalid pattern: BAD_PAT ← 1; CHAR and CHAR_SEEN unchanged.
  - Re-committing a digit already seen overwrites its CHAR.
- Word assembly:
  - When CHAR_SEEN = 111 after edge E, the next edge E+1 loads WORD ← {CHAR2, CHAR1, CHAR0}, sets WORD_VALID=1 and clears CHAR_SEEN.
  - Latency from the third qualifying sample to WORD_VALID: 1 cycle.
- Handshake:
  - WORD_VALID stays high and WORD stays stable until an edge with WORD_ACK=1, which clears WORD_VALID.
  - WORD_ACK while WORD_VALID=0 is ignored.
  - Load and ack on the same edge: load wins, WORD_VALID stays 1, no OVERRUN.
  - Load while WORD_VALID=1 without ack: WORD is overwritten and OVERRUN ← 1.
- Flags:
  - CLR_FLAGS clears BAD_PAT and OVERRUN.
  - A set and CLR_FLAGS on the same edge: set wins.

Optional Feature:
- Macro SEG7_ROTATION_DETECT_EN.
- Defined:
  - A previous-word register (cleared on reset, updated on every word load) is added.
  - On each load, ROT ← 1 if the new word equals the previous word rotated left one digit, {prev[3:0], prev[5:4]}; otherwise ROT ← 0.
  - The first load after reset always gives ROT=0.
  - ROT holds until the next load.
- Undefined: ROT is tied 0 and no previous-word register exists.

Test Plan:
1. STABLE_CYCLES=4; 4 samples each of dig0=1001111, dig1=0110000, dig2=0111101 → WORD=001001 (0x09), WORD_VALID rises 1 cycle after the 12th sample, holds until WORD_ACK, then clears the next edge.
2. dig0: 3× 1001111 then 1× 0110000 → no commit, CHAR_SEEN=000; 3 more 0110000 → CHAR_SEEN=001, char0=10.
3. dig1: 4× 1111111 → BAD_PAT=1, CHAR_SEEN unchanged; CLR_FLAGS pulse → BAD_PAT=0.
4. Two full words with no ack between → OVERRUN=1, WORD = second word; repeat with WORD_ACK on the load edge → no OVERRUN.
5. (SEG7_ROTATION_DETECT_EN) word 001001 then 100100 → ROT=1 on the second load; a third word 100100 → ROT=0.
6. Drop Resetn after 2 digits are committed → all outputs 0; complete dig2 only → no WORD_VALID.
